// File: rtl/wb_single_master_if.sv
// Wishbone B4 classic bus bundle between one master and one slave.
// Latency: none, wires only.
// Backpressure: the slave stalls the master by withholding wb_ack_i.
interface wb_single_master_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int SW = 4
);
   logic          wb_cyc_o;
   logic          wb_stb_o;
   logic          wb_we_o;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [SW-1:0] wb_sel_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/wb_single_master.sv
// Wishbone B4 classic master: one single READ/WRITE cycle per accepted command.
// Latency: STB from accept edge to ack edge, response strobe the cycle after, one GAP cycle.
// Backpressure: cmd_ready_o only in IDLE; WB_SINGLE_MASTER_TIMEOUT_EN adds an ack-timeout abort.
module wb_single_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SW      = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_we_i,
   input  logic [AW-1:0] cmd_adr_i,
   input  logic [DW-1:0] cmd_dat_i,
   input  logic [SW-1:0] cmd_sel_i,
   output logic          rsp_valid_o,
   output logic [DW-1:0] rsp_dat_o,
   output logic          rsp_err_o,
   output logic          busy_o,
   wb_single_master_if.master wb
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CYCLE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic [SW-1:0] sel_q, sel_d;
   logic          rsp_vld_q, rsp_vld_d;
   logic [DW-1:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rsp_err_q, rsp_err_d;
   logic          to_hit;

   // abort fires on the edge where the wait count would reach TIMEOUT
   assign to_hit    = (cnt_q == CW'(TIMEOUT - 1));
   assign rsp_err_o = rsp_err_q;

   // wait counter: zero while idle, so it is clear on entry to CYCLE
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE)
         cnt_d = '0;
      else if (state_q == S_CYCLE && !wb.wb_ack_i)
         cnt_d = cnt_q + CW'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign rsp_err_o      = 1'b0;
`endif

   assign cmd_ready_o = (state_q == S_IDLE) && wb_rst_i;
   assign busy_o      = (state_q != S_IDLE);
   assign rsp_valid_o = rsp_vld_q;
   assign rsp_dat_o   = rsp_dat_q;

   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_stb_o = cyc_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_sel_o = sel_q;

   // next-state: launch a cycle on accept, close it on ack (or timeout), then one gap cycle
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      rsp_vld_d = 1'b0;
      rsp_dat_d = rsp_dat_q;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
      rsp_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               cyc_d   = 1'b1;
               we_d    = cmd_we_i;
               adr_d   = cmd_adr_i;
               dat_d   = cmd_dat_i;
               sel_d   = cmd_sel_i;
               state_d = S_CYCLE;
            end
         end
         S_CYCLE: begin
            // ack has priority over a timeout on the same edge
            if (wb.wb_ack_i) begin
               cyc_d     = 1'b0;
               we_d      = 1'b0;
               rsp_vld_d = 1'b1;
               rsp_dat_d = we_q ? '0 : wb.wb_dat_i;
               state_d   = S_GAP;
            end
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
            else if (to_hit) begin
               cyc_d     = 1'b0;
               we_d      = 1'b0;
               rsp_vld_d = 1'b1;
               rsp_err_d = 1'b1;
               rsp_dat_d = '0;
               state_d   = S_GAP;
            end
`endif
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state and registered bus/response outputs, synchronous active-low reset
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q   <= S_IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= '0;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
         rsp_err_q <= 1'b0;
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         sel_q     <= sel_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_dat_q <= rsp_dat_d;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
         rsp_err_q <= rsp_err_d;
         cnt_q     <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_wb_single_master.sv
// Bench for wb_single_master: transaction-level model, per-cycle compare, directed stimulus.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: slave model withholds ack for a programmable number of cycles.
module tb_wb_single_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 8;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b1;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [DW-1:0] cmd_dat;
   logic [SW-1:0] cmd_sel;
   logic          rsp_valid, rsp_err, busy;
   logic [DW-1:0] rsp_dat;

   wb_single_master_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

   wb_single_master #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .cmd_sel_i   (cmd_sel),
      .rsp_valid_o (rsp_valid),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .busy_o      (busy),
      .wb          (bus.master)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // slave: ack after slv_wait cycles of STB; force_ack drives a stray ack while STB is low
   int            slv_wait = 0;
   bit            force_ack = 1'b0;
   logic [DW-1:0] slv_data = '0;
   int            s_cnt = 0;
   always @(negedge clk) begin
      if (bus.wb_stb_o) begin
         bus.wb_ack_i = (s_cnt == slv_wait);
         s_cnt++;
      end else begin
         bus.wb_ack_i = force_ack;
         s_cnt = 0;
      end
      bus.wb_dat_i = slv_data;
   end

   // transaction model: one outstanding command, ends on ack or after TO unacked edges,
   // next accept no earlier than two edges after the end edge
   int            edge_n = 0, t_end = -10, n_acc = 0, n_rsp = 0, m_cnt = 0;
   bit            m_out = 1'b0;
   logic          m_we = 1'b0;
   logic [AW-1:0] m_adr = '0;
   logic [DW-1:0] m_dat = '0;
   logic [SW-1:0] m_sel = '0;
   logic          e_vld = 1'b0, e_err = 1'b0;
   logic [DW-1:0] e_rdat = '0;
   always @(posedge clk) begin
      bit rdy;
      edge_n++;
      rdy = rst_n && !m_out && (edge_n >= t_end + 2);
      if (!rst_n) begin
         m_out = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
         e_vld = 1'b0; e_err = 1'b0; e_rdat = '0; t_end = -10;
      end else begin
         e_vld = 1'b0;
         e_err = 1'b0;
         if (m_out) begin
            m_cnt++;
            if (bus.wb_ack_i) begin
               e_vld  = 1'b1;
               e_rdat = m_we ? '0 : bus.wb_dat_i;
            end else if (TO_EN && m_cnt == TO) begin
               e_vld  = 1'b1;
               e_err  = 1'b1;
               e_rdat = '0;
            end
            if (e_vld) begin
               m_out = 1'b0; m_we = 1'b0; t_end = edge_n; n_rsp++;
            end
         end else if (rdy && cmd_valid) begin
            m_out = 1'b1; m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat; m_sel = cmd_sel;
            m_cnt = 0; n_acc++;
         end
      end
   end

   // per-cycle compare against the model, plus counters used by the literal checks
   int stb_hi = 0, stb_rise = 0, dut_rsp = 0;
   bit prev_stb = 1'b0;
   always @(posedge clk) begin
      #1;
      chk("cyc",       bus.wb_cyc_o, m_out);
      chk("stb",       bus.wb_stb_o, m_out);
      chk("we",        bus.wb_we_o,  m_we);
      chk("adr",       bus.wb_adr_o, m_adr);
      chk("dat_o",     bus.wb_dat_o, m_dat);
      chk("sel",       bus.wb_sel_o, m_sel);
      chk("rsp_valid", rsp_valid, e_vld);
      chk("rsp_err",   rsp_err,   e_err);
      chk("rsp_dat",   rsp_dat,   e_rdat);
      chk("busy",      busy,      m_out || (edge_n == t_end));
      chk("cmd_ready", cmd_ready, rst_n && !m_out && (edge_n + 1 >= t_end + 2));
      if (bus.wb_stb_o) stb_hi++;
      if (bus.wb_stb_o && !prev_stb) stb_rise++;
      if (rsp_valid) dut_rsp++;
      prev_stb = bus.wb_stb_o;
   end

   // one command: wait for accept and for its response, report STB cycles and response
   task automatic xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, output int stb_cyc, output logic [DW-1:0] rd,
                       output logic er);
      int  a0 = n_acc, r0 = n_rsp, h0 = stb_hi;
      bit  ok = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = a; cmd_dat = d; cmd_sel = s;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (n_acc != a0) begin ok = 1'b1; break; end
      end
      cmd_valid = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (n_rsp != r0) begin ok = 1'b1; break; end
            @(negedge clk);
         end
      end
      if (!ok) chk("xact_bound", 64'd0, 64'd1);
      stb_cyc = stb_hi - h0;
      rd = rsp_dat;
      er = rsp_err;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, i1, i4, r0, h0, a0;
      logic [DW-1:0] rd;
      logic        er;
      bit          ok;

      // 1: reset held with a pending command
      rst_n = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h40;
      cmd_dat = 32'h1234_5678; cmd_sel = 4'h3;
      repeat (6) @(negedge clk);
      chk("rst_stb_cycles", stb_hi, 0);
      chk("rst_ready", cmd_ready, 0);
      rst_n = 1'b1;
      #1 chk("post_rel_stb", bus.wb_stb_o, 0);
      @(posedge clk);
      #2 chk("second_cycle_stb", bus.wb_stb_o, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);

      // 2: write, ack one cycle after STB
      slv_wait = 1;
      xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, n, rd, er);
      chk("wr_stb_cycles", n, 2);
      chk("wr_rsp_dat", rd, 0);
      chk("wr_rsp_err", er, 0);

      // 3: read with three wait states, then the gap cycle
      slv_wait = 3; slv_data = 32'hDEAD_BEEF;
      xact(1'b0, 32'h0000_0010, 32'h0, 4'hF, n, rd, er);
      chk("rd_stb_cycles", n, 4);
      chk("rd_rsp_dat", rd, 32'hDEAD_BEEF);
      chk("gap_ready", cmd_ready, 0);
      @(negedge clk);
      chk("after_gap_ready", cmd_ready, 1);

      // zero-wait read at top address, partial selects
      slv_wait = 0; slv_data = 32'hA5A5_1234;
      xact(1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h5, n, rd, er);
      chk("zw_stb_cycles", n, 1);
      chk("zw_rsp_dat", rd, 32'hA5A5_1234);

      // stray ack while idle produces nothing
      repeat (2) @(negedge clk);
      r0 = dut_rsp;
      force_ack = 1'b1;
      repeat (5) @(negedge clk);
      force_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("stray_ack_rsp", dut_rsp - r0, 0);

      // 4: back-to-back commands, zero-wait slave
      slv_data = 32'h0BAD_F00D; r0 = dut_rsp; h0 = stb_rise; a0 = n_acc;
      i1 = 0; i4 = 0; ok = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h100;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (n_acc == a0 + 1 && i1 == 0) i1 = i + 1;
         if (n_acc == a0 + 4) begin i4 = i + 1; ok = 1'b1; break; end
      end
      cmd_valid = 1'b0;
      chk("b2b_bound", ok, 1);
      chk("b2b_spacing", i4 - i1, 9);
      repeat (6) @(negedge clk);
      chk("b2b_stb_rises", stb_rise - h0, 4);
      chk("b2b_rsps", dut_rsp - r0, 4);

      // 5: reset in the middle of a cycle
      slv_wait = 100; a0 = n_acc; r0 = dut_rsp;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h200; cmd_dat = 32'h55;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (n_acc != a0) break;
      end
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_cyc_before", bus.wb_cyc_o, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #2 chk("mid_rst_cyc", bus.wb_cyc_o, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_rst_no_rsp", dut_rsp - r0, 0);
      slv_wait = 0; slv_data = 32'h0000_00C3;
      xact(1'b0, 32'h300, 32'h0, 4'h1, n, rd, er);
      chk("recover_rsp_dat", rd, 32'h0000_00C3);

      // 6: ack on the last allowed edge is a normal response
      slv_wait = 7; slv_data = 32'h7777_0008;
      xact(1'b0, 32'h400, 32'h0, 4'hF, n, rd, er);
      chk("ack8_stb_cycles", n, 8);
      chk("ack8_err", er, 0);
      chk("ack8_dat", rd, 32'h7777_0008);
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
      slv_wait = 1000;
      xact(1'b0, 32'h500, 32'h0, 4'hF, n, rd, er);
      chk("to_stb_cycles", n, 8);
      chk("to_err", er, 1);
      chk("to_dat", rd, 0);
      slv_wait = 0;
`endif
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_single_master.md
Name: wb_single_master

Overview:
- Wishbone B4 classic single-cycle master (initiator) that drives the SDRAM controller's slave port in the testbench and in the system top.
- Converts a simple valid/ready command interface into one classic single READ or single WRITE cycle at a time.
- Returns read data and status on a one-cycle response strobe.
- Bus behaviour meets the reset rules 3.00/3.05/3.10 and the single read/write rule 3.25 by construction.

Parameters:
AW, 32, address width
DW, 32, data width
SW, 4, byte-select width (DW/8)
TIMEOUT, 255, max cycles waiting for ack before abort (only used with the optional feature)

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge
wb_rst_i  in  1  reset, synchronous, active-low
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when valid&ready at clock edge
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  AW  address
cmd_dat_i  in  DW  write data
cmd_sel_i  in  SW  byte selects
rsp_valid_o  out  1  one-cycle response strobe
rsp_dat_o  out  DW  read data (0 for writes)
rsp_err_o  out  1  timeout abort flag, valid with rsp_valid_o
busy_o  out  1  state != IDLE
wb_cyc_o  out  1  Wishbone CYC
wb_stb_o  out  1  Wishbone STB
wb_we_o  out  1  Wishbone WE
wb_adr_o  out  AW  Wishbone ADR
wb_dat_o  out  DW  Wishbone DAT (master to slave)
wb_sel_o  out  SW  Wishbone SEL
wb_dat_i  in  DW  Wishbone DAT (slave to master)
wb_ack_i  in  1  Wishbone ACK

Behaviour:
- All Wishbone and response outputs are registered.
- Reset (wb_rst_i=0 at an edge):
  - state=IDLE.
  - wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o = 0.
  - rsp_valid_o, rsp_err_o = 0; rsp_dat_o = 0; timeout counter = 0.
  - cmd_ready_o=0 while wb_rst_i=0.
- Reset mid-cycle: cyc/stb drop at that edge; the pending command is discarded with no response.
- STB is never high during reset or in the first cycle after reset release. The earliest STB is the second cycle after release.
- FSM states are IDLE, CYCLE, GAP.
- IDLE:
  - cmd_ready_o=1 (combinational: state==IDLE && wb_rst_i).
  - On valid&ready at an edge: latch we/adr/dat/sel into wb_* outputs, set cyc=stb=1 at that same edge, go to CYCLE.
  - wb_dat_o is loaded for reads too, but is don't-care.
- CYCLE:
  - cyc, stb, we, adr, dat and sel are held stable until ack.
  - At the first edge with wb_ack_i=1: cyc=stb=0 and we=0; rsp_valid_o=1 for exactly one cycle.
  - rsp_dat_o = wb_dat_i if read, 0 if write; rsp_err_o=0; go to GAP.
- GAP:
  - One mandatory idle cycle with cmd_ready_o=0, so every STB/WE assertion is a fresh rising edge. Then go to IDLE.
  - rsp_valid_o returns to 0.
- wb_ack_i outside CYCLE is ignored; no response is produced.
- Latency:
  - Command accepted at edge N gives cyc/stb high during N..M, where M is the edge sampling ack.
  - rsp_valid_o is high for cycle M..M+1.
  - The next command is accepted at edge M+2 at the earliest.
  - Zero-wait slave: 3 cycles per transaction.
- rsp_dat_o holds its last value between responses.

Optional Feature:
- Macro WB_SINGLE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to CYCLE and increments each CYCLE cycle without ack.
  - When the count reaches TIMEOUT with no ack at that edge: cyc=stb=0, rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0, go to GAP.
  - Ack on the same edge as timeout wins: normal response, err=0.
- Undefined: no counter; CYCLE waits indefinitely; rsp_err_o is tied 0.

Test Plan:
1. Reset held low 5 cycles with cmd_valid_i=1 -> cyc/stb/we=0 throughout and cmd_ready_o=0; after release, stb stays 0 for ≥1 cycle.
2. Write adr=0x0000_0010, dat=0xDEAD_BEEF, sel=0xF, slave acks 1 cycle after stb -> cyc=stb=we=1 for 2 cycles, then cyc=stb=0; rsp_valid one cycle, rsp_dat=0, err=0.
3. Read adr=0x0000_0010, slave returns 0xDEAD_BEEF with 3 wait cycles -> we=0, adr stable 4 cycles, rsp_dat=0xDEAD_BEEF, then a 1-cycle gap before cmd_ready_o=1.
4. Back-to-back commands held valid, zero-wait slave -> one transaction every 3 cycles; stb shows a rising edge for each transaction.
5. wb_rst_i=0 asserted while in CYCLE -> cyc/stb=0 next edge; no rsp_valid; state returns to IDLE.
6. With WB_SINGLE_MASTER_TIMEOUT_EN defined, TIMEOUT=8, no ack -> abort after 8 cycles with rsp_err=1, rsp_dat=0; with ack arriving exactly at count 8 -> err=0.
